// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//   Main control FSM of the multicycle RV32I core. Decodes the latched
//   instruction fields and the ALU flags, and drives every data_path control
//   input plus mem_write to data memory. One instruction at a time, 3-5 cycles
//   each (2 for an illegal opcode). Outputs are a combinational function of
//   state, opcode/funct fields and ALU flags.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   op, funct3, funct7b5        instruction fields (instr[6:0], [14:12], [30])
//   zero, cout, overflow, sign  ALU flags of the current-cycle operation
//   imm_src                     000 I, 001 S, 010 B, 011 J, 100 U
//   alu_control                 0 ADD/SUB,1 AND,2 OR,3 XOR,4 SLT,5 SLTU,
//                               6 SLL,7 SRL,8 SRA
//   add_sub_mode                1 = subtract
//   alu_src_a                   0 pc, 1 old_pc, 2 A
//   alu_src_b                   0 rs2, 1 imm_ext, 2 const 4
//   result_src                  0 alu_out, 1 data, 2 alu_result, 3 imm_ext
//   adr_src                     0 pc, 1 result
//   ir_write, pc_write, reg_write, mem_write   write enables
//   instr_done                  pulse in the last cycle of a legal instruction
//   illegal_instr               pulse in DECODE for an unsupported opcode
//   state_dbg                   current state encoding
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       cout,
    input  logic       overflow,
    input  logic       sign,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       add_sub_mode,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_JALR_LINK = 4'd12,
        S_LUI       = 4'd13,
        S_AUIPC     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Branch condition from funct3 and the flags of the rs1-rs2 subtraction.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic c, input logic v, input logic s);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return s ^ v;
            3'b101:  return ~(s ^ v);
            3'b110:  return ~c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    // ALU operation for R/I-type: returns {alu_control, add_sub_mode}.
    // SUB only exists for R-type; I-type funct7b5 is part of the immediate
    // except for shifts, where it selects SRAI.
    function automatic logic [4:0] alu_decode(input logic [2:0] f3, input logic f7,
                                              input logic is_r);
        case (f3)
            3'b000:  return {4'd0, is_r & f7};
            3'b001:  return {4'd6, 1'b0};
            3'b010:  return {4'd4, 1'b1};
            3'b011:  return {4'd5, 1'b1};
            3'b100:  return {4'd3, 1'b0};
            3'b101:  return f7 ? {4'd8, 1'b0} : {4'd7, 1'b0};
            3'b110:  return {4'd2, 1'b0};
            3'b111:  return {4'd1, 1'b0};
            default: return {4'd0, 1'b0};
        endcase
    endfunction

    state_t state_r;
    state_t next_state_s;
    logic   ir_write_s, pc_write_s, reg_write_s, mem_write_s;
    logic   instr_done_s, illegal_instr_s;

    // State register; reset returns to FETCH and aborts any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= state_t'(RESET_STATE);
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        next_state_s    = S_FETCH;
        imm_src         = 3'b000;
        alu_control     = 4'd0;
        add_sub_mode    = 1'b0;
        alu_src_a       = 2'd0;
        alu_src_b       = 2'd0;
        result_src      = 2'd0;
        adr_src         = 1'b0;
        ir_write_s      = 1'b0;
        pc_write_s      = 1'b0;
        reg_write_s     = 1'b0;
        mem_write_s     = 1'b0;
        instr_done_s    = 1'b0;
        illegal_instr_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_b    = 2'd2;
                result_src   = 2'd2;
                pc_write_s   = 1'b1;
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                // Precompute old_pc + imm as a branch/jal target.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                case (op)
                    OP_BR:            imm_src = 3'b010;
                    OP_JAL:           imm_src = 3'b011;
                    OP_SW:            imm_src = 3'b001;
                    OP_LUI, OP_AUIPC: imm_src = 3'b100;
                    default:          imm_src = 3'b000;
                endcase
                case (op)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_R:         next_state_s = S_EXEC_R;
                    OP_I:         next_state_s = S_EXEC_I;
                    OP_BR:        next_state_s = S_BRANCH;
                    OP_JAL:       next_state_s = S_JAL;
                    OP_JALR:      next_state_s = S_JALR;
                    OP_LUI:       next_state_s = S_LUI;
                    OP_AUIPC:     next_state_s = S_AUIPC;
                    default: begin
                        next_state_s    = S_FETCH;
                        illegal_instr_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 2'd2;
                alu_src_b    = 2'd1;
                imm_src      = op[5] ? 3'b001 : 3'b000;
                next_state_s = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src      = 1'b1;
                next_state_s = S_MEMWB;
            end
            S_MEMWB: begin
                result_src   = 2'd1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a                   = 2'd2;
                {alu_control, add_sub_mode} = alu_decode(funct3, funct7b5, 1'b1);
                next_state_s                = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a                   = 2'd2;
                alu_src_b                   = 2'd1;
                {alu_control, add_sub_mode} = alu_decode(funct3, funct7b5, 1'b0);
                next_state_s                = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 2'd2;
                add_sub_mode = 1'b1;
                pc_write_s   = branch_taken(funct3, zero, cout, overflow, sign);
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                // pc <= target held in alu_out while the ALU forms old_pc+4.
                alu_src_a    = 2'd1;
                alu_src_b    = 2'd2;
                pc_write_s   = 1'b1;
                next_state_s = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a    = 2'd2;
                alu_src_b    = 2'd1;
                result_src   = 2'd2;
                pc_write_s   = 1'b1;
                next_state_s = S_JALR_LINK;
            end
            S_JALR_LINK: begin
                alu_src_a    = 2'd1;
                alu_src_b    = 2'd2;
                result_src   = 2'd2;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_LUI: begin
                imm_src      = 3'b100;
                result_src   = 2'd3;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_AUIPC: begin
                alu_src_a    = 2'd1;
                alu_src_b    = 2'd1;
                imm_src      = 3'b100;
                next_state_s = S_ALUWB;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // Reset masks every enable and pulse so an aborted instruction writes nothing.
    assign ir_write      = ir_write_s      & ~reset;
    assign pc_write      = pc_write_s      & ~reset;
    assign reg_write     = reg_write_s     & ~reset;
    assign mem_write     = mem_write_s     & ~reset;
    assign instr_done    = instr_done_s    & ~reset;
    assign illegal_instr = illegal_instr_s & ~reset;
    assign state_dbg     = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, cout, overflow, sign;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       add_sub_mode;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic       adr_src, ir_write, pc_write, reg_write, mem_write;
    logic       instr_done, illegal_instr;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int step = 0;
    bit chk = 1'b0;
    int done_cnt = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .cout(cout), .overflow(overflow), .sign(sign),
        .imm_src(imm_src), .alu_control(alu_control), .add_sub_mode(add_sub_mode),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem_write(mem_write), .instr_done(instr_done),
        .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (op=%b f3=%b step=%0d)",
                     name, act, exp, op, funct3, step);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111 ||
               o == 7'b1100111 || o == 7'b0110111 || o == 7'b0010111;
    endfunction

    // Cycles per instruction including FETCH.
    function automatic int ncyc(input logic [6:0] o);
        case (o)
            7'b0000011: return 5;
            7'b1100011, 7'b0110111: return 3;
            7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b0010111: return 4;
            default: return 2;
        endcase
    endfunction

    // Expected control vector for cycle k of an instruction, from the
    // per-instruction timeline. Packed as
    // {imm,alu,sub,a,b,res,adr,irw,pcw,rw,mw,done,ill}.
    function automatic logic [20:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic c,
                                          input logic v, input logic s, input int k);
        logic [2:0] imm; logic [3:0] alu; logic sub;
        logic [1:0] a, b, rs;
        logic adr, irw, pcw, rw, mw, dn, il;
        imm = 3'd0; alu = 4'd0; sub = 1'b0; a = 2'd0; b = 2'd0; rs = 2'd0;
        adr = 1'b0; irw = 1'b0; pcw = 1'b0; rw = 1'b0; mw = 1'b0; dn = 1'b0; il = 1'b0;
        if (k == 0) begin
            irw = 1'b1; pcw = 1'b1; b = 2'd2; rs = 2'd2;
        end else if (k == 1) begin
            a = 2'd1; b = 2'd1;
            if (o == 7'b1100011) imm = 3'd2;
            else if (o == 7'b1101111) imm = 3'd3;
            else if (o == 7'b0100011) imm = 3'd1;
            else if (o == 7'b0110111 || o == 7'b0010111) imm = 3'd4;
            il = !is_legal(o);
        end else begin
            case (o)
                7'b0000011: begin
                    if (k == 2) begin a = 2'd2; b = 2'd1; end
                    if (k == 3) adr = 1'b1;
                    if (k == 4) begin rs = 2'd1; rw = 1'b1; dn = 1'b1; end
                end
                7'b0100011: begin
                    if (k == 2) begin a = 2'd2; b = 2'd1; imm = 3'd1; end
                    if (k == 3) begin adr = 1'b1; mw = 1'b1; dn = 1'b1; end
                end
                7'b0110011, 7'b0010011: begin
                    if (k == 2) begin
                        a = 2'd2;
                        b = (o == 7'b0010011) ? 2'd1 : 2'd0;
                        case (f3)
                            3'b000: begin alu = 4'd0; sub = (o == 7'b0110011) && f7; end
                            3'b001: alu = 4'd6;
                            3'b010: begin alu = 4'd4; sub = 1'b1; end
                            3'b011: begin alu = 4'd5; sub = 1'b1; end
                            3'b100: alu = 4'd3;
                            3'b101: alu = f7 ? 4'd8 : 4'd7;
                            3'b110: alu = 4'd2;
                            default: alu = 4'd1;
                        endcase
                    end
                    if (k == 3) begin rw = 1'b1; dn = 1'b1; end
                end
                7'b1100011: begin
                    a = 2'd2; sub = 1'b1; dn = 1'b1;
                    case (f3)
                        3'b000: pcw = z;
                        3'b001: pcw = !z;
                        3'b100: pcw = (s != v);
                        3'b101: pcw = (s == v);
                        3'b110: pcw = !c;
                        3'b111: pcw = c;
                        default: pcw = 1'b0;
                    endcase
                end
                7'b1101111: begin
                    if (k == 2) begin a = 2'd1; b = 2'd2; pcw = 1'b1; end
                    if (k == 3) begin rw = 1'b1; dn = 1'b1; end
                end
                7'b1100111: begin
                    if (k == 2) begin a = 2'd2; b = 2'd1; rs = 2'd2; pcw = 1'b1; end
                    if (k == 3) begin a = 2'd1; b = 2'd2; rs = 2'd2; rw = 1'b1; dn = 1'b1; end
                end
                7'b0110111: begin imm = 3'd4; rs = 2'd3; rw = 1'b1; dn = 1'b1; end
                7'b0010111: begin
                    if (k == 2) begin a = 2'd1; b = 2'd1; imm = 3'd4; end
                    if (k == 3) begin rw = 1'b1; dn = 1'b1; end
                end
                default: ;
            endcase
        end
        return {imm, alu, sub, a, b, rs, adr, irw, pcw, rw, mw, dn, il};
    endfunction

    // Compare process: every checked cycle against the model, plus pinned literals.
    always @(negedge clk) begin
        if (chk) begin
            logic [20:0] exp_v, act_v;
            exp_v = model(op, funct3, funct7b5, zero, cout, overflow, sign, step);
            act_v = {imm_src, alu_control, add_sub_mode, alu_src_a, alu_src_b, result_src,
                     adr_src, ir_write, pc_write, reg_write, mem_write, instr_done,
                     illegal_instr};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL ctrl_vec op=%b f3=%b step=%0d: got %h expected %h",
                         op, funct3, step, act_v, exp_v);
            end
            if (instr_done) done_cnt = done_cnt + 1;
            if (step == 0) lit("fetch_state", 8'(state_dbg), 8'd0);
            if (op == 7'b0000011) lit("lw_reg_write", 8'(reg_write), (step == 4) ? 8'd1 : 8'd0);
            if (op == 7'b0110011 && funct3 == 3'b000 && funct7b5 && step == 2) begin
                lit("sub_alu", 8'(alu_control), 8'd0);
                lit("sub_mode", 8'(add_sub_mode), 8'd1);
                lit("sub_a", 8'(alu_src_a), 8'd2);
                lit("sub_b", 8'(alu_src_b), 8'd0);
            end
            if (op == 7'b0110011 && step == 3) lit("aluwb_rw", 8'(reg_write), 8'd1);
            if (op == 7'b1100111 && step == 2) begin
                lit("jalr_pcw", 8'(pc_write), 8'd1);
                lit("jalr_rw", 8'(reg_write), 8'd0);
            end
            if (op == 7'b1100111 && step == 3) begin
                lit("link_rw", 8'(reg_write), 8'd1);
                lit("link_a", 8'(alu_src_a), 8'd1);
                lit("link_b", 8'(alu_src_b), 8'd2);
            end
            if (op == 7'b1111111 && step == 1) begin
                lit("ill_pulse", 8'(illegal_instr), 8'd1);
                lit("ill_wen", 8'({ir_write, pc_write, reg_write, mem_write}), 8'd0);
            end
            if (op == 7'b1100011 && funct3 == 3'b000 && step == 2)
                lit("beq_pcw", 8'(pc_write), zero ? 8'd1 : 8'd0);
        end
    end

    // Runs one instruction from FETCH for its full cycle count.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input logic c, input logic v, input logic s);
        int n;
        op = o; funct3 = f3; funct7b5 = f7; zero = z; cout = c; overflow = v; sign = s;
        n = ncyc(o);
        done_cnt = 0;
        for (int k = 0; k < n; k++) begin
            step = k;
            chk = 1'b1;
            @(posedge clk);
            #1;
        end
        chk = 1'b0;
        lit("done_count", 8'(done_cnt), is_legal(o) ? 8'd1 : 8'd0);
    endtask

    initial begin
        reset = 1'b1;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; cout = 1'b0; overflow = 1'b0; sign = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        lit("rst_state", 8'(state_dbg), 8'd0);
        lit("rst_wen", 8'({ir_write, pc_write, reg_write, mem_write, instr_done}), 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // lw
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // sw
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // add
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // sub
        run_instr(7'b0110011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // sra
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // and
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addi, imm bit30 set
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // slti
        run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // srai
        run_instr(7'b0010011, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // sltiu
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // beq not taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // bne taken
        run_instr(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // blt taken
        run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); // bge taken
        run_instr(7'b1100011, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // bltu not taken
        run_instr(7'b1100011, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // bgeu taken
        run_instr(7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); // undefined funct3
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // jal
        run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // jalr
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // lui
        run_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // auipc
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // illegal
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // illegal

        // sw aborted by reset in MEMWRITE: nothing may be written.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit("abort_mem_write", 8'(mem_write), 8'd0);
            lit("abort_done", 8'(instr_done), 8'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // restart from FETCH
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
